adder_arbiter: RTL and testbench

Round-robin arbiter that shares one `WORD`-wide `adder` instance between `NREQ` requesters in the MIPS datapath, such as PC increment, branch target and address generation. It grants one requester at a time, latches that requester's operands into the shared adder, and returns a tagged, registered result. The result is held under a valid/acknowledge handshake.

---
 rtl/adder_arbiter_if.sv | 41 ++++
 rtl/adder_arbiter.sv | 176 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: request/operand/result bundle between the requesters,
// the result consumer and the shared-adder arbiter.
// Optional: ADDER_ARB_CARRY_EN adds the carry_out signal.
interface adder_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int WORD = 32
);
   logic [NREQ-1:0]      req;
   logic [NREQ*WORD-1:0] a_in;
   logic [NREQ*WORD-1:0] b_in;
   logic [NREQ-1:0]      gnt;
   logic                 busy;
   logic [WORD-1:0]      sum_out;
   logic [IDW-1:0]       sum_id;
   logic                 sum_valid;
   logic                 res_ack;
`ifdef ADDER_ARB_CARRY_EN
   logic                 carry_out;

   modport master (
      output req, a_in, b_in, res_ack,
      input  gnt, busy, sum_out, sum_id, sum_valid, carry_out
   );

   modport slave (
      input  req, a_in, b_in, res_ack,
      output gnt, busy, sum_out, sum_id, sum_valid, carry_out
   );
`else
   modport master (
      output req, a_in, b_in, res_ack,
      input  gnt, busy, sum_out, sum_id, sum_valid
   );

   modport slave (
      input  req, a_in, b_in, res_ack,
      output gnt, busy, sum_out, sum_id, sum_valid
   );
`endif
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one WORD-wide adder between
// NREQ requesters. The winner's operands are latched, summed in CALC and the
// tagged result is held in DONE until acknowledged.
// Optional: ADDER_ARB_CARRY_EN adds a registered carry_out next to sum_out.
module adder_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int WORD = 32
) (
   input  logic         clk,
   input  logic         rst,
   adder_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [NREQ-1:0] gnt_r;
   logic [NREQ-1:0] gnt_nxt_s;
   logic            busy_r;
   logic            sum_valid_r;
   logic            sum_valid_nxt_s;
   logic [WORD-1:0] op_a_r;
   logic [WORD-1:0] op_b_r;
   logic [WORD-1:0] sum_r;
   logic [WORD-1:0] sum_s;
   logic [IDW-1:0]  sum_id_r;
   logic [IDW-1:0]  ptr_r;
   logic [IDW-1:0]  ptr_nxt_s;
   logic [IDW-1:0]  win_s;
   logic            win_vld_s;
   logic            grant_s;
   logic            capture_s;
`ifdef ADDER_ARB_CARRY_EN
   logic            carry_r;
`endif

   // Round-robin search: first asserted request at or after p, wrapping.
   // Returns {found, index}.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IDW-1:0]  p);
      logic           found;
      logic [IDW-1:0] w;
      int             idx;
      found = 1'b0;
      w     = {IDW{1'b0}};
      for (int off = 0; off < NREQ; off++) begin
         idx = int'(p) + off;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!found && r[idx]) begin
            found = 1'b1;
            w     = IDW'(idx);
         end
      end
      return {found, w};
   endfunction

   assign {win_vld_s, win_s} = rr_pick(bus.req, ptr_r);

   // The shared adder; wraps modulo 2^WORD.
   assign sum_s = op_a_r + op_b_r;

   // Pointer moves one past the winner, wrapping at NREQ.
   always_comb begin
      if (win_s == IDW'(NREQ - 1)) begin
         ptr_nxt_s = {IDW{1'b0}};
      end else begin
         ptr_nxt_s = win_s + {{(IDW-1){1'b0}}, 1'b1};
      end
   end

   // Next-state logic of the IDLE/CALC/DONE controller.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (win_vld_s) begin
               state_nxt_s = CALC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CALC: state_nxt_s = DONE;
         DONE: begin
            if (bus.res_ack) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output/control decode: grant only from IDLE, capture in CALC, ack in DONE.
   always_comb begin
      grant_s         = 1'b0;
      capture_s       = 1'b0;
      gnt_nxt_s       = {NREQ{1'b0}};
      sum_valid_nxt_s = sum_valid_r;
      case (state_r)
         IDLE: begin
            if (win_vld_s) begin
               grant_s   = 1'b1;
               gnt_nxt_s = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
            end else begin
               grant_s   = 1'b0;
            end
         end
         CALC: begin
            capture_s       = 1'b1;
            sum_valid_nxt_s = 1'b1;
         end
         DONE: begin
            if (bus.res_ack) begin
               sum_valid_nxt_s = 1'b0;
            end else begin
               sum_valid_nxt_s = sum_valid_r;
            end
         end
         default: sum_valid_nxt_s = 1'b0;
      endcase
   end

   // State, operand, result and pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         gnt_r       <= {NREQ{1'b0}};
         busy_r      <= 1'b0;
         sum_valid_r <= 1'b0;
         op_a_r      <= {WORD{1'b0}};
         op_b_r      <= {WORD{1'b0}};
         sum_r       <= {WORD{1'b0}};
         sum_id_r    <= {IDW{1'b0}};
         ptr_r       <= {IDW{1'b0}};
`ifdef ADDER_ARB_CARRY_EN
         carry_r     <= 1'b0;
`endif
      end else begin
         state_r     <= state_nxt_s;
         gnt_r       <= gnt_nxt_s;
         busy_r      <= (state_nxt_s != IDLE);
         sum_valid_r <= sum_valid_nxt_s;
         if (grant_s) begin
            op_a_r   <= bus.a_in[win_s*WORD +: WORD];
            op_b_r   <= bus.b_in[win_s*WORD +: WORD];
            sum_id_r <= win_s;
            ptr_r    <= ptr_nxt_s;
         end
         if (capture_s) begin
            sum_r    <= sum_s;
`ifdef ADDER_ARB_CARRY_EN
            carry_r  <= (sum_s < op_a_r);
`endif
         end
      end
   end

   assign bus.gnt       = gnt_r;
   assign bus.busy      = busy_r;
   assign bus.sum_out   = sum_r;
   assign bus.sum_id    = sum_id_r;
   assign bus.sum_valid = sum_valid_r;
`ifdef ADDER_ARB_CARRY_EN
   assign bus.carry_out = carry_r;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scenario-driven bench for adder_arbiter (WORD=42, NREQ=4)
// with a queue of expected results pushed at stimulus time.
module tb_adder_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int WORD = 42;

   typedef struct packed {
      logic [IDW-1:0]  id;
      logic [WORD-1:0] sum;
      logic            carry;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   exp_t exp_q[$];

   adder_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .WORD(WORD)) bus ();

   adder_arbiter #(.NREQ(NREQ), .IDW(IDW), .WORD(WORD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // gnt must be one-hot and never coincide with sum_valid
   always @(negedge clk) begin
      if (bus.gnt != 4'b0000 || bus.sum_valid) begin
         n_checks++;
         if ((bus.gnt != 4'b0000 && bus.sum_valid) || !$onehot0(bus.gnt)) begin
            $display("FAIL gnt_vs_valid: gnt=%b sum_valid=%b required one-hot gnt, not both",
                     bus.gnt, bus.sum_valid);
         end else begin
            n_pass++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_ops(input int i, input logic [WORD-1:0] a, input logic [WORD-1:0] b);
      bus.a_in[i*WORD +: WORD] = a;
      bus.b_in[i*WORD +: WORD] = b;
   endtask

   // One transaction with res_ack high; returns what was observed (no checks).
   task automatic observe_txn(input logic [3:0] r, output logic [3:0] g, output logic v,
                              output logic [WORD-1:0] s, output logic [IDW-1:0] id,
                              output logic c, output logic idle_after);
      bus.req = r;
      @(negedge clk);
      g = bus.gnt;
      bus.req = 4'b0000;
      @(negedge clk);
      v  = bus.sum_valid;
      s  = bus.sum_out;
      id = bus.sum_id;
`ifdef ADDER_ARB_CARRY_EN
      c  = bus.carry_out;
`else
      c  = 1'b0;
`endif
      @(negedge clk);
      idle_after = !bus.busy && !bus.sum_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req = 4'b0000;
      bus.res_ack = 1'b0;
      bus.a_in = '0;
      bus.b_in = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.sum_valid !== 1'b0 ||
          bus.sum_out !== 42'd0 || bus.sum_id !== 2'd0) begin
         $display("FAIL reset_values: gnt=%b busy=%b valid=%b sum=%0d id=%0d required all 0",
                  bus.gnt, bus.busy, bus.sum_valid, bus.sum_out, bus.sum_id);
      end else begin
         n_pass++;
      end
`ifdef ADDER_ARB_CARRY_EN
      n_checks++;
      if (bus.carry_out !== 1'b0) $display("FAIL reset_carry: got %b required 0", bus.carry_out);
      else n_pass++;
`endif
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [3:0] g; logic v; logic [WORD-1:0] s; logic [IDW-1:0] id; logic c; logic idl;
      exp_t e;
      bus.res_ack = 1'b1;
      set_ops(0, 42'd1, 42'd1);
      exp_q.push_back('{id: 2'd0, sum: 42'd2, carry: 1'b0});
      bus.req = 4'b0001;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1 || bus.sum_valid !== 1'b0) begin
         $display("FAIL basic_grant: gnt=%b busy=%b valid=%b required 0001/1/0",
                  bus.gnt, bus.busy, bus.sum_valid);
      end else n_pass++;
      bus.req = 4'b0000;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.gnt !== 4'b0000 || bus.sum_valid !== 1'b1 || bus.sum_out !== e.sum ||
          bus.sum_id !== e.id) begin
         $display("FAIL basic_result: gnt=%b valid=%b sum=%0d id=%0d required 0000/1/%0d/%0d",
                  bus.gnt, bus.sum_valid, bus.sum_out, bus.sum_id, e.sum, e.id);
      end else n_pass++;
`ifdef ADDER_ARB_CARRY_EN
      n_checks++;
      if (bus.carry_out !== e.carry) $display("FAIL basic_carry: got %b required %b", bus.carry_out, e.carry);
      else n_pass++;
`endif
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.sum_valid !== 1'b0) begin
         $display("FAIL basic_idle: busy=%b valid=%b required 0/0", bus.busy, bus.sum_valid);
      end else n_pass++;
      // ptr is now 1: a lone request from 0 must still be granted
      set_ops(0, 42'd5, 42'd7);
      exp_q.push_back('{id: 2'd0, sum: 42'd12, carry: 1'b0});
      observe_txn(4'b0001, g, v, s, id, c, idl);
      e = exp_q.pop_front();
      n_checks++;
      if (g !== 4'b0001 || v !== 1'b1 || s !== e.sum || id !== e.id || idl !== 1'b1) begin
         $display("FAIL skip_wrap: gnt=%b valid=%b sum=%0d id=%0d idle=%b required 0001/1/%0d/%0d/1",
                  g, v, s, id, idl, e.sum, e.id);
      end else n_pass++;
   endtask

   task automatic test_pointer_skip();
      logic [3:0] g; logic v; logic [WORD-1:0] s; logic [IDW-1:0] id; logic c; logic idl;
      exp_t e;
      // ptr stayed at 1 after the wrap, so 1 beats 0
      set_ops(0, 42'd9, 42'd9);
      set_ops(1, 42'd40, 42'd2);
      exp_q.push_back('{id: 2'd1, sum: 42'd42, carry: 1'b0});
      observe_txn(4'b0011, g, v, s, id, c, idl);
      e = exp_q.pop_front();
      n_checks++;
      if (g !== 4'b0010 || v !== 1'b1 || s !== e.sum || id !== e.id) begin
         $display("FAIL ptr_after_skip: gnt=%b valid=%b sum=%0d id=%0d required 0010/1/%0d/%0d",
                  g, v, s, id, e.sum, e.id);
      end else n_pass++;
   endtask

   task automatic test_wrap_carry();
      logic [3:0] g; logic v; logic [WORD-1:0] s; logic [IDW-1:0] id; logic c; logic idl;
      exp_t e;
      set_ops(2, 42'h3FF_FFFF_FFFE, 42'd1);
      exp_q.push_back('{id: 2'd2, sum: 42'h3FF_FFFF_FFFF, carry: 1'b0});
      observe_txn(4'b0100, g, v, s, id, c, idl);
      e = exp_q.pop_front();
      n_checks++;
      if (g !== 4'b0100 || v !== 1'b1 || s !== e.sum || id !== e.id) begin
         $display("FAIL max_no_wrap: gnt=%b valid=%b sum=%0d id=%0d required 0100/1/%0d/%0d",
                  g, v, s, id, e.sum, e.id);
      end else n_pass++;
`ifdef ADDER_ARB_CARRY_EN
      n_checks++;
      if (c !== e.carry) $display("FAIL max_no_wrap_carry: got %b required %b", c, e.carry);
      else n_pass++;
`endif
      set_ops(2, 42'h3FF_FFFF_FFFF, 42'd1);
      exp_q.push_back('{id: 2'd2, sum: 42'd0, carry: 1'b1});
      observe_txn(4'b0100, g, v, s, id, c, idl);
      e = exp_q.pop_front();
      n_checks++;
      if (g !== 4'b0100 || v !== 1'b1 || s !== e.sum || id !== e.id) begin
         $display("FAIL wrap_sum: gnt=%b valid=%b sum=%0d id=%0d required 0100/1/%0d/%0d",
                  g, v, s, id, e.sum, e.id);
      end else n_pass++;
`ifdef ADDER_ARB_CARRY_EN
      n_checks++;
      if (c !== e.carry) $display("FAIL wrap_carry: got %b required %b", c, e.carry);
      else n_pass++;
`endif
   endtask

   task automatic test_mid_reset();
      logic [3:0] g; logic v; logic [WORD-1:0] s; logic [IDW-1:0] id; logic c; logic idl;
      exp_t e;
      set_ops(3, 42'd77, 42'd1);
      bus.req = 4'b1000;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b1000) $display("FAIL mid_reset_grant: got %b required 1000", bus.gnt);
      else n_pass++;
      bus.req = 4'b0000;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.sum_valid !== 1'b0 ||
          bus.sum_out !== 42'd0 || bus.sum_id !== 2'd0) begin
         $display("FAIL mid_reset_clear: gnt=%b busy=%b valid=%b sum=%0d id=%0d required all 0",
                  bus.gnt, bus.busy, bus.sum_valid, bus.sum_out, bus.sum_id);
      end else n_pass++;
`ifdef ADDER_ARB_CARRY_EN
      n_checks++;
      if (bus.carry_out !== 1'b0) $display("FAIL mid_reset_carry: got %b required 0", bus.carry_out);
      else n_pass++;
`endif
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0000 || bus.sum_valid !== 1'b0) begin
         $display("FAIL mid_reset_no_regrant: gnt=%b valid=%b required 0000/0", bus.gnt, bus.sum_valid);
      end else n_pass++;
      set_ops(0, 42'd10, 42'd20);
      exp_q.push_back('{id: 2'd0, sum: 42'd30, carry: 1'b0});
      observe_txn(4'b1001, g, v, s, id, c, idl);
      e = exp_q.pop_front();
      n_checks++;
      if (g !== 4'b0001 || v !== 1'b1 || s !== e.sum || id !== e.id || idl !== 1'b1) begin
         $display("FAIL post_reset_ptr: gnt=%b valid=%b sum=%0d id=%0d idle=%b required 0001/1/%0d/%0d/1",
                  g, v, s, id, idl, e.sum, e.id);
      end else n_pass++;
   endtask

   task automatic test_backpressure();
      exp_t e;
      logic [WORD-1:0] held;
      // ptr is 1 here, so requester 1 wins first, then 2 after the ack
      set_ops(1, 42'd58984575, 42'd2154879571);
      set_ops(2, 42'd58984575, 42'd2154879571);
      exp_q.push_back('{id: 2'd1, sum: 42'd2213864146, carry: 1'b0});
      exp_q.push_back('{id: 2'd2, sum: 42'd2213864146, carry: 1'b0});
      bus.res_ack = 1'b0;
      bus.req = 4'b0110;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0010) $display("FAIL bp_grant: got %b required 0010", bus.gnt);
      else n_pass++;
      @(negedge clk);
      e = exp_q.pop_front();
      held = bus.sum_out;
      n_checks++;
      if (bus.sum_valid !== 1'b1 || bus.sum_out !== e.sum || bus.sum_id !== e.id) begin
         $display("FAIL bp_result: valid=%b sum=%0d id=%0d required 1/%0d/%0d",
                  bus.sum_valid, bus.sum_out, bus.sum_id, e.sum, e.id);
      end else n_pass++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.sum_valid !== 1'b1 || bus.sum_out !== held || bus.sum_id !== e.id ||
             bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin
            $display("FAIL bp_hold[%0d]: valid=%b sum=%0d id=%0d gnt=%b busy=%b required 1/%0d/%0d/0000/1",
                     i, bus.sum_valid, bus.sum_out, bus.sum_id, bus.gnt, bus.busy, held, e.id);
         end else n_pass++;
      end
      bus.res_ack = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.sum_valid !== 1'b0 || bus.gnt !== 4'b0000) begin
         $display("FAIL bp_ack: valid=%b gnt=%b required 0/0000", bus.sum_valid, bus.gnt);
      end else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0100) $display("FAIL bp_next_grant: got %b required 0100", bus.gnt);
      else n_pass++;
      bus.req = 4'b0000;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.sum_valid !== 1'b1 || bus.sum_out !== e.sum || bus.sum_id !== e.id) begin
         $display("FAIL bp_second: valid=%b sum=%0d id=%0d required 1/%0d/%0d",
                  bus.sum_valid, bus.sum_out, bus.sum_id, e.sum, e.id);
      end else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      exp_t       e;
      logic [3:0] want;
      int         budget;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.res_ack = 1'b1;
      for (int i = 0; i < NREQ; i++) set_ops(i, WORD'(100 + i), WORD'(i));
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back('{id: IDW'(k % NREQ), sum: WORD'(100 + 2 * (k % NREQ)), carry: 1'b0});
      end
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         budget = 0;
         do begin
            @(negedge clk);
            budget++;
         end while (bus.gnt == 4'b0000 && budget < 10);
         e = exp_q.pop_front();
         want = 4'b0001 << e.id;
         if (k == 4) bus.req = 4'b0000;
         n_checks++;
         if (bus.gnt !== want || budget > 3) begin
            $display("FAIL rr_grant[%0d]: gnt=%b after %0d cycles required %b within 3",
                     k, bus.gnt, budget, want);
         end else n_pass++;
         @(negedge clk);
         n_checks++;
         if (bus.sum_valid !== 1'b1 || bus.sum_id !== e.id || bus.sum_out !== e.sum) begin
            $display("FAIL rr_result[%0d]: valid=%b id=%0d sum=%0d required 1/%0d/%0d",
                     k, bus.sum_valid, bus.sum_id, bus.sum_out, e.id, e.sum);
         end else n_pass++;
      end
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      test_reset();
      test_basic();
      test_pointer_skip();
      test_wrap_carry();
      test_mid_reset();
      test_backpressure();
      test_round_robin();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
